// File: rtl/aidc_lite_zrle_unpacker.sv
// Zero-run-length unpacker: expands 16-bit literal/run tokens into a 16x64-bit block of buffer writes.
// Latency: the write carrying a token's last byte appears 1 cycle after that token leaves the FIFO head.
// Backpressure: ready_o is registered and high only while at least two token slots are free; words are never dropped.
module aidc_lite_zrle_unpacker #(
  parameter int FIFO_DEPTH = 8,
  parameter int BLK_WORDS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic [31:0]                  data_i,
  output logic                         valid_o,
  output logic [$clog2(BLK_WORDS)-1:0] addr_o,
  output logic [63:0]                  data_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int AW        = $clog2(BLK_WORDS);
  localparam int BLK_BYTES = BLK_WORDS * 8;
  localparam int CW        = $clog2(BLK_BYTES + 1);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int FCW       = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_FULL} state_t;

  // Tokens are stored trimmed to {type[1:0], byte[7:0]}; bits [13:8] carry no meaning.
  logic [9:0]     fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  state_t         state_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    asm_q, asm_d;
  logic           run_act_q, run_act_d;
  logic [8:0]     run_rem_q, run_rem_d;
  logic           eop_seen_q;
  logic           ready_q, valid_q, done_q, err_q;
  logic [AW-1:0]  addr_q;
  logic [63:0]    data_q;

  logic           accept, take_sop, push_word, pop, tok_err, word_done, fifo_empty;
  logic [9:0]     head;
  logic [2:0]     off;
  logic [5:0]     boff;
  logic [3:0]     space, step;
  logic [8:0]     cur_len;
  logic           unused_bits;

  assign unused_bits = ^{data_i[13:8], data_i[29:24]};

  assign accept     = valid_i & ready_q;
  assign take_sop   = accept & sop_i;
  // Non-sop words only belong to an open block whose eop has not yet arrived.
  assign push_word  = accept & ~sop_i & (state_q != S_IDLE) & ~eop_seen_q;
  assign fifo_empty = (fcnt_q == '0);
  assign head       = fifo_q[rptr_q];

  // Token decode and byte-count / assembly next-state for the current cycle.
  always_comb begin
    off       = cnt_q[2:0];
    boff      = {off, 3'b000};
    space     = 4'd8 - {1'b0, off};
    cur_len   = run_act_q ? run_rem_q : ({1'b0, head[7:0]} + 9'd1);
    step      = (cur_len < {5'd0, space}) ? cur_len[3:0] : space;
    pop       = 1'b0;
    tok_err   = 1'b0;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    run_act_d = run_act_q;
    run_rem_d = run_rem_q;
    case (state_q)
      S_RUN: begin
        if (!fifo_empty) begin
          unique case (head[9:8])
            2'b00: begin
              asm_d[boff +: 8] = head[7:0];
              cnt_d            = cnt_q + CW'(1);
              pop              = 1'b1;
            end
            2'b10: begin
              // Zero bytes need no assembly write: the register is cleared per word.
              cnt_d     = cnt_q + CW'(step);
              run_rem_d = cur_len - {5'd0, step};
              if (run_rem_d == 9'd0) begin
                pop       = 1'b1;
                run_act_d = 1'b0;
              end else if (cnt_d == CW'(BLK_BYTES)) begin
                pop       = 1'b1;
                run_act_d = 1'b0;
                tok_err   = 1'b1;
              end else begin
                run_act_d = 1'b1;
              end
            end
            2'b11: pop = 1'b1;
            default: begin
              pop     = 1'b1;
              tok_err = 1'b1;
            end
          endcase
        end
      end
      S_FLUSH: cnt_d = {cnt_q[CW-1:3] + (CW-3)'(1), 3'b000};
      S_FULL: begin
        pop     = !fifo_empty;
        tok_err = pop && (head[9:8] != 2'b11);
      end
      default: ;
    endcase
    word_done = (cnt_d[CW-1:3] != cnt_q[CW-1:3]);
    fcnt_d    = take_sop ? FCW'(2)
              : fcnt_q + (push_word ? FCW'(2) : FCW'(0)) - (pop ? FCW'(1) : FCW'(0));
  end

  // Token storage; a sop word restarts the FIFO at slot 0, discarding older tokens.
  always_ff @(posedge clk) begin
    if (take_sop) begin
      fifo_q[0] <= {data_i[15:14], data_i[7:0]};
      fifo_q[1] <= {data_i[31:30], data_i[23:16]};
    end else if (push_word) begin
      fifo_q[wptr_q]          <= {data_i[15:14], data_i[7:0]};
      fifo_q[wptr_q + PW'(1)] <= {data_i[31:30], data_i[23:16]};
    end
  end

  // Block FSM, FIFO pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fcnt_q     <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      run_act_q  <= 1'b0;
      run_rem_q  <= '0;
      eop_seen_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fcnt_q  <= fcnt_d;
      ready_q <= (fcnt_d <= FCW'(FIFO_DEPTH - 2));
      if (take_sop) begin
        rptr_q <= '0;
        wptr_q <= PW'(2);
      end else begin
        if (push_word) wptr_q <= wptr_q + PW'(2);
        if (pop)       rptr_q <= rptr_q + PW'(1);
      end
      if (take_sop) begin
        // A sop mid-block aborts the old block and flags it on the new one.
        state_q    <= S_RUN;
        cnt_q      <= '0;
        asm_q      <= '0;
        run_act_q  <= 1'b0;
        run_rem_q  <= '0;
        eop_seen_q <= eop_i;
        addr_q     <= '0;
        done_q     <= 1'b0;
        err_q      <= (state_q == S_RUN) || (state_q == S_FLUSH);
      end else begin
        if (push_word && eop_i) eop_seen_q <= 1'b1;
        cnt_q     <= cnt_d;
        run_act_q <= run_act_d;
        run_rem_q <= run_rem_d;
        asm_q     <= word_done ? '0 : asm_d;
        if (word_done) begin
          valid_q <= 1'b1;
          addr_q  <= cnt_q[AW+2:3];
          data_q  <= asm_d;
        end
        if (tok_err) err_q <= 1'b1;
        case (state_q)
          S_RUN: begin
            if (cnt_d == CW'(BLK_BYTES))       state_q <= S_FULL;
            else if (fifo_empty && eop_seen_q) state_q <= S_FLUSH;
          end
          S_FLUSH: begin
            if (cnt_d == CW'(BLK_BYTES)) begin
              err_q   <= 1'b1;
              state_q <= S_FULL;
            end
          end
          S_FULL: begin
            done_q <= 1'b1;
            if (fifo_empty && eop_seen_q) state_q <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_aidc_lite_zrle_unpacker.sv
// Directed bench for the ZRLE unpacker: expected buffer writes are queued when a block is sent
// and compared in order as the write strobe fires; block-level done/err/count checks follow each block.
module tb_aidc_lite_zrle_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        sop_i = 1'b0;
  logic        eop_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        ready_o, valid_o, done_o, err_o;
  logic [3:0]  addr_o;
  logic [63:0] data_o;

  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  bit          saw_stall = 1'b0;
  logic [67:0] exp_q [$];

  aidc_lite_zrle_unpacker #(.FIFO_DEPTH(8), .BLK_WORDS(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sop_i   (sop_i),
    .eop_i   (eop_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    logic [67:0] e;
    if (!rst && valid_o) begin
      wr_cnt++;
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(addr_o), 64'(e[67:64]));
        check("wr_data", data_o, e[63:0]);
      end
    end
  end

  task automatic push_blk(input logic [63:0] w0, input logic [63:0] w15);
    for (int a = 0; a < 16; a++)
      exp_q.push_back({4'(a), (a == 0) ? w0 : ((a == 15) ? w15 : 64'd0)});
  endtask

  task automatic send(input logic s, input logic e, input logic [31:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    valid_i = 1'b1; sop_i = s; eop_i = e; data_i = d;
    while (!acc && n < 200) begin
      acc = ready_o;
      if (!acc) saw_stall = 1'b1;
      @(negedge clk);
      n++;
    end
    check("send_accept", 64'(acc), 64'd1);
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_wr_count"}, 64'(wr_cnt), 64'd16);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : stim
    logic [63:0] d;
    int          n;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_addr",  64'(addr_o),  64'd0);
    check("rst_data",  data_o,       64'd0);
    check("rst_done",  64'(done_o),  64'd0);
    check("rst_err",   64'(err_o),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: NOP + run of 256 in one sop/eop word, clipped at 128
    wr_cnt = 0;
    push_blk(64'd0, 64'd0);
    send(1'b1, 1'b1, 32'h80FF_C000);
    wait_done("t1");
    check("t1_err", 64'(err_o), 64'd1);
    repeat (4) @(negedge clk);

    // 2: 128 literals streamed back-to-back
    wr_cnt = 0;
    saw_stall = 1'b0;
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(w*8 + k);
      exp_q.push_back({4'(w), d});
    end
    for (int i = 0; i < 64; i++)
      send(i == 0, i == 63, {8'h00, 8'(2*i + 1), 8'h00, 8'(2*i)});
    wait_done("t2");
    check("t2_ready_dropped", 64'(saw_stall), 64'd1);
    check("t2_err", 64'(err_o), 64'd0);
    repeat (4) @(negedge clk);

    // 3: literal, run 126, literal exactly fill the block
    wr_cnt = 0;
    push_blk(64'h0000_0000_0000_00AA, 64'h5500_0000_0000_0000);
    send(1'b1, 1'b0, 32'h807D_00AA);
    send(1'b0, 1'b1, 32'hC000_0055);
    wait_done("t3");
    check("t3_err", 64'(err_o), 64'd0);
    repeat (4) @(negedge clk);

    // 4: early eop -> zero-filled flush and underflow error
    wr_cnt = 0;
    push_blk(64'h0000_0000_0033_2211, 64'd0);
    send(1'b1, 1'b0, 32'h0022_0011);
    send(1'b0, 1'b1, 32'hC000_0033);
    wait_done("t4");
    check("t4_err", 64'(err_o), 64'd1);
    repeat (4) @(negedge clk);

    // 5: reserved token mid-block takes no byte position
    wr_cnt = 0;
    push_blk(64'h0000_0000_0000_2211, 64'h3300_0000_0000_0000);
    send(1'b1, 1'b0, 32'h4000_0011);
    send(1'b0, 1'b0, 32'h807C_0022);
    send(1'b0, 1'b1, 32'hC000_0033);
    wait_done("t5");
    check("t5_err", 64'(err_o), 64'd1);
    repeat (4) @(negedge clk);

    // 6: reset at byte 40 aborts the block, then a clean block follows
    wr_cnt = 0;
    push_blk(64'd0, 64'd0);
    send(1'b1, 1'b0, 32'hC000_80FF);
    n = 0;
    while (!(valid_o && addr_o == 4'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_byte40", 64'(valid_o && addr_o == 4'd4), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t6_rst_valid", 64'(valid_o), 64'd0);
    check("t6_rst_ready", 64'(ready_o), 64'd1);
    check("t6_rst_done",  64'(done_o),  64'd0);
    repeat (2) @(negedge clk);
    check("t6_idle_valid", 64'(valid_o), 64'd0);
    wr_cnt = 0;
    push_blk(64'h0000_0000_0000_00AA, 64'h5500_0000_0000_0000);
    send(1'b1, 1'b0, 32'h807D_00AA);
    send(1'b0, 1'b1, 32'hC000_0055);
    wait_done("t6");
    check("t6_err", 64'(err_o), 64'd0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
